// File: rtl/soc_rst_seq_pkg.sv
// Shared types and default timing for the SoC reset sequencer.
package soc_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SYS_RST   = 2'd1,
        ST_CPU_HOLD  = 2'd2,
        ST_RUN       = 2'd3
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR     = 2'd0,
        CAUSE_LOCK    = 2'd1,
        CAUSE_SYS_BTN = 2'd2,
        CAUSE_CPU     = 2'd3
    } rst_cause_e;

    localparam int DEBOUNCE_CYCLES_DEF  = 16;
    localparam int SYS_RST_CYCLES_DEF   = 32;
    localparam int CPU_DELAY_CYCLES_DEF = 16;
    localparam int CNT_W_DEF            = 8;

endpackage

// File: rtl/soc_rst_seq_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw button.
module soc_rst_seq_debounce
    import soc_rst_seq_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   CNT_W           = CNT_W_DEF,
    parameter logic RST_VAL         = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic db_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_comb begin
        db_d  = db_q;
        cnt_d = {CNT_W{1'b0}};
        if (sync2_q != db_q) begin
            if (cnt_q >= CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, debounce counter and debounced level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            db_q    <= RST_VAL;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/soc_rst_seq.sv
// Reset sequencer: conditions board reset sources, releases bus reset then CPU reset,
// and records what caused the most recent re-entry into reset.
module soc_rst_seq
    import soc_rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int SYS_RST_CYCLES   = SYS_RST_CYCLES_DEF,
    parameter int CPU_DELAY_CYCLES = CPU_DELAY_CYCLES_DEF,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    input  logic       rst_sys_btn_i,
    input  logic       rst_cpu_btn_i,
    input  logic       dbg_cpu_rst_req_i,
    output logic       rst_sys_o,
    output logic       rst_cpu_o,
    output logic       ready_o,
    output logic [1:0] rst_cause_o
);

    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             lock_sync1_q;
    logic             lock_sync2_q;
    logic             sys_db_s;
    logic             cpu_db_s;
    logic             cpu_db_prev_q;
    logic             cpu_evt_s;
    rst_state_e       state_q;
    rst_state_e       state_d;
    rst_cause_e       cause_q;
    rst_cause_e       cause_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rst_sys_q;
    logic             rst_cpu_q;
    logic             ready_q;

    soc_rst_seq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RST_VAL         (1'b1)
    ) u_sys_db (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .raw_i   (rst_sys_btn_i),
        .db_o    (sys_db_s)
    );

    soc_rst_seq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RST_VAL         (1'b1)
    ) u_cpu_db (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .raw_i   (rst_cpu_btn_i),
        .db_o    (cpu_db_s)
    );

    // In CPU_HOLD only a fresh press restarts the delay; a held button just blocks RUN.
    assign cpu_evt_s = dbg_cpu_rst_req_i |
                       ((state_q == ST_RUN) ? cpu_db_s : (cpu_db_s & ~cpu_db_prev_q));

    // Next state, shared counter and cause; lock loss beats sys button beats CPU request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if ((state_q != ST_WAIT_LOCK) && !lock_sync2_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
            cause_d = CAUSE_LOCK;
        end else if ((state_q != ST_WAIT_LOCK) && sys_db_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
            cause_d = CAUSE_SYS_BTN;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_sync2_q && !sys_db_s) begin
                        state_d = ST_SYS_RST;
                        cnt_d   = SYS_LAST;
                    end else begin
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end
                ST_SYS_RST: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_CPU_HOLD;
                        cnt_d   = CPU_LAST;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                ST_CPU_HOLD: begin
                    if (cpu_evt_s) begin
                        cnt_d   = CPU_LAST;
                        cause_d = CAUSE_CPU;
                    end else if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end else if (!cpu_db_s) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (cpu_evt_s) begin
                        state_d = ST_CPU_HOLD;
                        cnt_d   = CPU_LAST;
                        cause_d = CAUSE_CPU;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter, cause, lock synchroniser and outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync1_q  <= 1'b0;
            lock_sync2_q  <= 1'b0;
            cpu_db_prev_q <= 1'b1;
            state_q       <= ST_WAIT_LOCK;
            cnt_q         <= {CNT_W{1'b0}};
            cause_q       <= CAUSE_POR;
            rst_sys_q     <= 1'b1;
            rst_cpu_q     <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            lock_sync1_q  <= pll_lock_i;
            lock_sync2_q  <= lock_sync1_q;
            cpu_db_prev_q <= cpu_db_s;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cause_q       <= cause_d;
            rst_sys_q     <= (state_d == ST_WAIT_LOCK) || (state_d == ST_SYS_RST);
            rst_cpu_q     <= (state_d != ST_RUN);
            ready_q       <= (state_d == ST_RUN);
        end
    end

    assign rst_sys_o   = rst_sys_q;
    assign rst_cpu_o   = rst_cpu_q;
    assign ready_o     = ready_q;
    assign rst_cause_o = cause_q;

endmodule
